// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader: FSM states, default
// frame marker and header length.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAY_LO,
    PAY_HI,
    CHK
  } state_e;

  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
  // start_idx (2 bytes) + count (2 bytes), little-endian.
  localparam int unsigned HDR_BYTES         = 4;

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte watchdog: reloads on every accepted byte and pulses expire_o
// once TIMEOUT_CYCLES clock cycles have elapsed without a reload.
module loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic run_i,
  output logic expire_o
);

  localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] cnt_q;

  // Down-counter: load to TIMEOUT_CYCLES, count down while the frame is open.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= W'(TIMEOUT_CYCLES);
    end else if (run_i && cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  // Fires on the edge that completes the TIMEOUT_CYCLES-th silent cycle.
  assign expire_o = run_i && !load_i && (cnt_q == W'(1));

endmodule

// File: rtl/program_loader.sv
// Parses framed load commands from a byte stream and writes the payload into
// the CPU instruction memory as 16-bit halfwords via the download port.
module program_loader
  import loader_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int unsigned MAX_HALFWORDS  = 256,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        download_program,
  output logic        program_we,
  output logic [31:0] instruction_index,
  output logic [15:0] program_in,
  output logic        load_done,
  output logic        load_error
);

  state_e      state_q, state_d;
  logic [1:0]  hdr_cnt_q, hdr_cnt_d;
  logic [23:0] hdr_q, hdr_d;          // first three header bytes, LSB first
  logic [15:0] start_idx_q, start_idx_d;
  logic [15:0] count_q, count_d;
  logic [15:0] hw_cnt_q, hw_cnt_d;    // halfwords written in this frame
  logic [7:0]  b0_q, b0_d;
  logic [7:0]  xor_q, xor_d;
  logic        dl_q, dl_d;
  logic        we_q, we_d;
  logic [31:0] idx_q, idx_d;
  logic [15:0] pin_q, pin_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        timer_load, timer_run, timer_expire;
  logic [31:0] hdr_full;
  logic [15:0] hw_next;

  assign timer_run = (state_q != IDLE);
  assign hdr_full  = {byte_data, hdr_q};
  assign hw_next   = hw_cnt_q + 16'd1;

  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (timer_load),
    .run_i   (timer_run),
    .expire_o(timer_expire)
  );

  // Frame parser: next state, datapath updates and output strobes.
  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    hdr_cnt_d   = hdr_cnt_q;
    hdr_d       = hdr_q;
    start_idx_d = start_idx_q;
    count_d     = count_q;
    hw_cnt_d    = hw_cnt_q;
    b0_d        = b0_q;
    xor_d       = xor_q;
    dl_d        = dl_q;
    we_d        = 1'b0;
    idx_d       = idx_q;
    pin_d       = pin_q;
    done_d      = done_q;
    err_d       = err_q;
    timer_load  = 1'b0;

    if (state_q == IDLE) begin
      if (byte_valid && byte_data == SYNC_BYTE) begin
        state_d    = HDR;
        hdr_cnt_d  = '0;
        xor_d      = '0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        timer_load = 1'b1;
      end
    end else if (byte_valid) begin
      // Inside a frame every byte is data, SYNC value included.
      timer_load = 1'b1;
      xor_d      = xor_q ^ byte_data;
      unique case (state_q)
        HDR: begin
          hdr_d     = {byte_data, hdr_q[23:8]};
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          if (hdr_cnt_q == 2'(HDR_BYTES - 1)) begin
            start_idx_d = hdr_full[15:0];
            count_d     = hdr_full[31:16];
            hw_cnt_d    = '0;
            if (32'(hdr_full[31:16]) > MAX_HALFWORDS) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end else if (hdr_full[31:16] == 16'd0) begin
              state_d = CHK;
            end else begin
              dl_d    = 1'b1;
              state_d = PAY_LO;
            end
          end
        end
        PAY_LO: begin
          b0_d    = byte_data;
          state_d = PAY_HI;
        end
        PAY_HI: begin
          we_d     = 1'b1;
          pin_d    = {b0_q, byte_data};
          idx_d    = {16'h0, start_idx_q} + {16'h0, hw_cnt_q};
          hw_cnt_d = hw_next;
          state_d  = (hw_next == count_q) ? CHK : PAY_LO;
        end
        CHK: begin
          dl_d    = 1'b0;
          done_d  = (byte_data == xor_q);
          err_d   = (byte_data != xor_q);
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (timer_expire) begin
      dl_d    = 1'b0;
      err_d   = 1'b1;
      state_d = IDLE;
    end
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hdr_cnt_q   <= '0;
      hdr_q       <= '0;
      start_idx_q <= '0;
      count_q     <= '0;
      hw_cnt_q    <= '0;
      b0_q        <= '0;
      xor_q       <= '0;
      dl_q        <= 1'b0;
      we_q        <= 1'b0;
      idx_q       <= '0;
      pin_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_cnt_q   <= hdr_cnt_d;
      hdr_q       <= hdr_d;
      start_idx_q <= start_idx_d;
      count_q     <= count_d;
      hw_cnt_q    <= hw_cnt_d;
      b0_q        <= b0_d;
      xor_q       <= xor_d;
      dl_q        <= dl_d;
      we_q        <= we_d;
      idx_q       <= idx_d;
      pin_q       <= pin_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign download_program  = dl_q;
  assign program_we        = we_q;
  assign instruction_index = idx_q;
  assign program_in        = pin_q;
  assign load_done         = done_q;
  assign load_error        = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed frames plus randomized
// frames, each checked against a frame-level model of the expected writes.
module tb_program_loader;

  localparam int TO    = 64;
  localparam int MAXHW = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        download_program, program_we, load_done, load_error;
  logic [31:0] instruction_index;
  logic [15:0] program_in;

  int total = 0;
  int bad   = 0;

  logic [47:0] obs_q[$];
  bit          dl_seen;

  always #5 clk = ~clk;

  program_loader #(
    .SYNC_BYTE     (8'hA5),
    .MAX_HALFWORDS (MAXHW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .byte_valid       (byte_valid),
    .byte_data        (byte_data),
    .download_program (download_program),
    .program_we       (program_we),
    .instruction_index(instruction_index),
    .program_in       (program_in),
    .load_done        (load_done),
    .load_error       (load_error)
  );

  // Record every write strobe and whether the download window opened.
  always @(negedge clk) begin
    if (rst_n) begin
      if (program_we) obs_q.push_back({instruction_index, program_in});
      if (download_program) dl_seen = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_data  = b;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  // Build a frame, send the first trunc bytes (all if trunc<0), then check
  // the halfword writes and the final status against the frame rules.
  task automatic send_frame(input logic [15:0] start, input logic [15:0] cnt,
                            input logic [7:0] pay[$], input bit corrupt,
                            input int trunc, input int max_gap, input bit reset_abort);
    logic [7:0]  fr[$];
    logic [7:0]  x;
    logic [47:0] exp_q[$];
    bit          over;
    int          n_send, pay_sent, pairs;

    over = (int'(cnt) > MAXHW);
    fr   = {8'hA5, start[7:0], start[15:8], cnt[7:0], cnt[15:8]};
    if (!over) begin
      foreach (pay[i]) fr.push_back(pay[i]);
      x = 8'h00;
      for (int i = 1; i < fr.size(); i++) x ^= fr[i];
      fr.push_back(corrupt ? (x ^ 8'h01) : x);
    end
    n_send = (trunc < 0 || trunc > fr.size()) ? fr.size() : trunc;

    obs_q.delete();
    dl_seen = 1'b0;
    for (int i = 0; i < n_send; i++) begin
      send_byte(fr[i]);
      if (i == 4) check("dl_after_hdr", download_program, (!over && cnt != 0));
      if (i < n_send - 1 && max_gap > 0) idle($urandom_range(max_gap, 0));
    end

    pay_sent = over ? 0 : ((n_send > 5) ? n_send - 5 : 0);
    if (pay_sent > 2 * int'(cnt)) pay_sent = 2 * int'(cnt);
    pairs = pay_sent / 2;
    for (int p = 0; p < pairs; p++)
      exp_q.push_back({32'(start) + 32'(p), pay[2*p], pay[2*p+1]});

    #1;
    check("wr_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("wr_%0d", i), obs_q[i], exp_q[i]);

    if (reset_abort) begin
      rst_n = 1'b0;
      #1;
      check("reset_outputs", {download_program, program_we, instruction_index,
                              program_in, load_done, load_error}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      obs_q.delete();
      idle(12);
      check("no_we_after_reset", obs_q.size(), 0);
      check("dl_after_reset", download_program, 1'b0);
      return;
    end

    if (over) begin
      check("over_err", load_error, 1'b1);
      check("over_done", load_done, 1'b0);
    end else if (n_send < fr.size()) begin
      idle(TO - 1);
      check("no_early_timeout", load_error, 1'b0);
      idle(1);
      check("timeout_err", load_error, 1'b1);
      check("timeout_done", load_done, 1'b0);
    end else begin
      check("done", load_done, !corrupt);
      check("err", load_error, corrupt);
    end
    check("dl_low_end", download_program, 1'b0);
    check("dl_window", dl_seen, (!over && cnt != 0 && n_send > 5));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] p[$];
    int         n, tr;

    idle(3);
    check("reset_state", {download_program, program_we, instruction_index,
                          program_in, load_done, load_error}, 64'd0);
    rst_n = 1'b1;
    idle(2);

    // Good two-halfword load.
    p = {8'h20, 8'h21, 8'h05, 8'h20};
    send_frame(16'd10, 16'd2, p, 1'b0, -1, 0, 1'b0);
    check("t1_wr0", (obs_q.size() > 0) ? obs_q[0] : 48'h0, {32'd10, 16'h2021});
    check("t1_wr1", (obs_q.size() > 1) ? obs_q[1] : 48'h0, {32'd11, 16'h0520});

    // Same frame with a bad checksum.
    send_frame(16'd10, 16'd2, p, 1'b1, -1, 0, 1'b0);

    // Timeout after the first halfword, then a good frame.
    send_frame(16'd10, 16'd2, p, 1'b0, 7, 0, 1'b0);
    send_frame(16'd10, 16'd2, p, 1'b0, -1, 2, 1'b0);

    // Oversize count, then the largest count crossing a 16-bit index boundary.
    p = {};
    send_frame(16'd0, 16'h0101, p, 1'b0, -1, 0, 1'b0);
    for (int i = 0; i < 2 * MAXHW; i++) p.push_back(8'($urandom));
    send_frame(16'hFFF0, 16'(MAXHW), p, 1'b0, -1, 0, 1'b0);

    // Zero count: header straight to checksum.
    p = {};
    send_frame(16'd10, 16'd0, p, 1'b0, -1, 0, 1'b0);

    // Noise in idle must not disturb the held status.
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    idle(2);
    check("noise_done_held", load_done, 1'b1);
    check("noise_no_we", obs_q.size(), 0);

    // SYNC value as index and payload data.
    p = {8'hA5, 8'hA5, 8'h12, 8'hA5};
    send_frame(16'h00A5, 16'd2, p, 1'b0, -1, 0, 1'b0);

    // Reset after the third payload byte.
    p = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_frame(16'd40, 16'd3, p, 1'b0, 8, 0, 1'b1);

    // Randomized frames with gaps, corruption and occasional truncation.
    for (int f = 0; f < 24; f++) begin
      n = $urandom_range(8, 1);
      p = {};
      for (int i = 0; i < 2 * n; i++)
        p.push_back(($urandom_range(3, 0) == 0) ? 8'hA5 : 8'($urandom));
      tr = ($urandom_range(3, 0) == 0) ? 5 + int'($urandom_range(2 * n, 0)) : -1;
      send_frame(16'($urandom), 16'(n), p, 1'($urandom_range(1, 0)), tr,
                 int'($urandom_range(3, 0)), 1'b0);
      idle(int'($urandom_range(2, 0)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
